// File: rtl/jk_bank_driver.sv
// Drives an external bank of JK flip-flops from a D-style write port.
// Each target word becomes J/K excitation, is verified by readback, and is retried on mismatch.
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter bit DC_MODE   = 1'b0,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             jk_rst,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  input  logic             err_clr
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_DRIVE  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [2:0]    RETRY_LAST  = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [2:0]       retry_q, retry_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic [WIDTH-1:0] j_d, k_d, err_mask_d;
  logic             jk_rst_d, wr_ready_d, busy_d, done_d, err_d;

  // Mode 0 excites only the bits that must change; mode 1 drives every bit.
  // Neither form can produce J=K=1, so the bank never toggles.
  function automatic logic [WIDTH-1:0] j_of(input logic [WIDTH-1:0] d,
                                            input logic [WIDTH-1:0] q);
    return DC_MODE ? d : (d & ~q);
  endfunction

  function automatic logic [WIDTH-1:0] k_of(input logic [WIDTH-1:0] d,
                                            input logic [WIDTH-1:0] q);
    return DC_MODE ? ~d : (~d & q);
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    shadow_d   = shadow_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    err_d      = err;
    err_mask_d = err_mask;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;

    unique case (state_q)
      S_INIT: begin
        shadow_d = '0;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (wr_valid) begin
          target_d = wr_data;
          retry_d  = '0;
          j_d      = j_of(wr_data, shadow_q);
          k_d      = k_of(wr_data, shadow_q);
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_CHECK;
        else                         settle_d = settle_q + 1'b1;
      end
      S_CHECK: begin
        if (q_fb == target_q) begin
          shadow_d = target_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (retry_q < RETRY_LAST) begin
          // Re-drive from what the bank actually holds, not from the shadow.
          retry_d = retry_q + 3'd1;
          j_d     = j_of(target_q, q_fb);
          k_d     = k_of(target_q, q_fb);
          state_d = S_DRIVE;
        end else begin
          err_d      = 1'b1;
          err_mask_d = q_fb ^ target_q;
          state_d    = S_ERR;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          err_d      = 1'b0;
          err_mask_d = '0;
          state_d    = S_INIT;
        end
      end
      default: state_d = S_INIT;
    endcase

    // State-decoded outputs are computed from the next state so they register in step with it.
    jk_rst_d   = (state_d == S_INIT);
    wr_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_INIT;
      target_q <= '0;
      shadow_q <= '0;
      retry_q  <= '0;
      settle_q <= '0;
      j_out    <= '0;
      k_out    <= '0;
      jk_rst   <= 1'b1;
      wr_ready <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      shadow_q <= shadow_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      j_out    <= j_d;
      k_out    <= k_d;
      jk_rst   <= jk_rst_d;
      wr_ready <= wr_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      err_mask <= err_mask_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (DC_MODE 0 and 1), each driving a modelled JK bank,
// checked every cycle against a timestamp-based transaction model plus directed literal checks.
module tb_jk_bank_driver;

  localparam int SETTLE    = 1;
  localparam int MAX_RETRY = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_valid = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic [7:0] stuck    = 8'h00;

  logic       wr_ready0, jk_rst0, busy0, done0, err0;
  logic [7:0] j0, k0, mask0;
  logic [7:0] q0 = 8'h00;
  logic       wr_ready1, jk_rst1, busy1, done1, err1;
  logic [7:0] j1, k1, mask1;
  logic [7:0] q1 = 8'h00;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b1;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(8), .DC_MODE(1'b0), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_data(wr_data),
    .j_out(j0), .k_out(k0), .jk_rst(jk_rst0), .q_fb(q0), .busy(busy0), .done(done0),
    .err(err0), .err_mask(mask0), .err_clr(err_clr)
  );

  jk_bank_driver #(.WIDTH(8), .DC_MODE(1'b1), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
    .j_out(j1), .k_out(k1), .jk_rst(jk_rst1), .q_fb(q1), .busy(busy1), .done(done1),
    .err(err1), .err_mask(mask1), .err_clr(err_clr)
  );

  // External JK banks: sync reset, Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  always @(posedge clk) begin
    q0 <= (jk_rst0 ? 8'h00 : ((j0 & ~q0) | (~k0 & q0))) & ~stuck;
    q1 <= (jk_rst1 ? 8'h00 : ((j1 & ~q1) | (~k1 & q1))) & ~stuck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] exc(input logic [7:0] d, input logic [7:0] q, input bit full);
    if (full) return {d, ~d};
    return {d & ~q, ~d & q};
  endfunction

  // Transaction model: the write schedule is kept as cycle timestamps.
  int         cyc          = 0;
  bit         init_pending = 1'b1;
  bit         m_err        = 1'b0;
  logic [7:0] m_mask       = 8'h00;
  logic [7:0] m_shadow     = 8'h00;
  logic [7:0] m_target     = 8'h00;
  logic [7:0] m_base       = 8'h00;
  int         m_retry      = 0;
  int         drive_cyc    = -1;
  int         check_cyc    = -1;
  int         done_cyc     = -1;
  int         free_cyc     = 0;

  always @(posedge clk) begin
    if (!rst) begin
      init_pending = 1'b1;
      m_err = 1'b0; m_mask = 8'h00; m_shadow = 8'h00;
      drive_cyc = -1; check_cyc = -1; done_cyc = -1; free_cyc = 0;
    end else if (init_pending) begin
      init_pending = 1'b0;
      m_shadow     = 8'h00;
      free_cyc     = cyc + 1;
    end else if (m_err) begin
      if (err_clr) begin
        m_err = 1'b0; m_mask = 8'h00; init_pending = 1'b1;
      end
    end else if (cyc >= free_cyc) begin
      if (wr_valid) begin
        m_target  = wr_data;
        m_base    = m_shadow;
        m_retry   = 0;
        drive_cyc = cyc + 1;
        check_cyc = cyc + 2 + SETTLE;
        free_cyc  = check_cyc + 1;
      end
    end else if (cyc == check_cyc) begin
      if (q0 == m_target) begin
        m_shadow = m_target;
        done_cyc = cyc + 1;
      end else if (m_retry < MAX_RETRY) begin
        m_retry++;
        m_base    = q0;
        drive_cyc = cyc + 1;
        check_cyc = cyc + 2 + SETTLE;
        free_cyc  = check_cyc + 1;
      end else begin
        m_err  = 1'b1;
        m_mask = q0 ^ m_target;
      end
    end
    cyc++;
  end

  // {jk_rst, wr_ready, busy, done, err, err_mask, j, k}
  function automatic logic [28:0] expect_vec(input bit full);
    bit idle;
    if (!rst || init_pending) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
    idle = !m_err && (cyc >= free_cyc);
    return {1'b0, idle, !idle, cyc == done_cyc, m_err, m_mask,
            (cyc == drive_cyc) ? exc(m_target, m_base, full) : 16'h0000};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_dut0", 32'({jk_rst0, wr_ready0, busy0, done0, err0, mask0, j0, k0}),
            32'(expect_vec(1'b0)));
      check("cycle_dut1", 32'({jk_rst1, wr_ready1, busy1, done1, err1, mask1, j1, k1}),
            32'(expect_vec(1'b1)));
      check("no_toggle", 32'((j0 & k0) | (j1 & k1)), 32'd0);
    end
  end

  initial begin
    int         drives;
    int         dones;
    int         n;
    logic [7:0] d_acc;
    logic [7:0] d2;

    // T1: reset for 3 cycles, then release.
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("t1_jk_rst_init", 32'(jk_rst0), 32'd1);
    check("t1_not_ready",   32'(wr_ready0), 32'd0);
    @(negedge clk);
    check("t1_jk_rst_low",  32'(jk_rst0), 32'd0);
    check("t1_ready",       32'(wr_ready0), 32'd1);
    check("t1_outs_zero",   32'({busy0, done0, err0, mask0, j0, k0}), 32'd0);

    // T2: 8'hA5 from shadow 0.
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t2_drive_j", 32'(j0), 32'h0A5);
    check("t2_drive_k", 32'(k0), 32'h000);
    repeat (3) @(negedge clk);
    check("t2_done_at_4", 32'(done0), 32'd1);
    check("t2_bank",      32'(q0), 32'h0A5);

    // T3: 8'h3C from shadow 8'hA5, accepted in the done cycle.
    check("t3_ready_in_done", 32'(wr_ready0), 32'd1);
    wr_valid = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t3_j_mode0", 32'(j0), 32'h018);
    check("t3_k_mode0", 32'(k0), 32'h081);
    check("t3_j_mode1", 32'(j1), 32'h03C);
    check("t3_k_mode1", 32'(k1), 32'h0C3);
    repeat (3) @(negedge clk);
    check("t3_done", 32'(done0), 32'd1);

    // T4: bit0 stuck at 0, write 8'h01 -> three drives then error.
    stuck = 8'h01; wr_valid = 1'b1; wr_data = 8'h01;
    @(negedge clk);
    wr_valid = 1'b0;
    drives = 0; n = 0;
    while (!err0 && n < 40) begin
      if ((j0 | k0) != 8'h00) drives++;
      @(negedge clk);
      n++;
    end
    check("t4_drive_count", 32'(drives), 32'd3);
    check("t4_err",         32'(err0), 32'd1);
    check("t4_err_mask",    32'(mask0), 32'h001);
    check("t4_not_ready",   32'(wr_ready0), 32'd0);
    stuck = 8'h00; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_init_pulse", 32'(jk_rst0), 32'd1);
    check("t4_err_clear",  32'(err0), 32'd0);
    @(negedge clk);
    check("t4_idle",       32'(wr_ready0), 32'd1);
    check("t4_bank_clear", 32'(q0), 32'h000);

    // T5: wr_valid held high while wr_data keeps changing.
    d_acc = 8'($urandom_range(1, 255));
    wr_valid = 1'b1; wr_data = d_acc;
    @(negedge clk);
    check("t5_drive_first", 32'(j0), 32'(d_acc));
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    check("t5_done",          32'(done0), 32'd1);
    check("t5_ready_in_done", 32'(wr_ready0), 32'd1);
    d2 = wr_data;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t5_second_j", 32'(j0), 32'(d2 & ~d_acc));
    check("t5_second_k", 32'(k0), 32'(~d2 & d_acc));
    repeat (3) @(negedge clk);

    // T6: reset asserted during SETTLE.
    wr_valid = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1 check("t6_async_reset", 32'({jk_rst0, wr_ready0, busy0, done0, err0, mask0, j0, k0}),
             32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0}));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check("t6_no_done",    32'(dones), 32'd0);
    check("t6_bank_clear", 32'(q0), 32'h000);

    // Randomised traffic with stuck bits, error clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      err_clr  = ($urandom_range(0, 7) == 0);
      if (i % 64 == 0)
        stuck = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (i % 400 == 399) begin
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
      end
    end
    wr_valid = 1'b0; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
